// File: rtl/stream_acc_pkg.sv
// Shared types and helpers for the stream accumulator: FSM state encoding
// and the sizing function for the beat counter.
package stream_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter has to hold the value CNT itself, not only CNT-1.
  function automatic int cnt_width(input int cnt);
    return $clog2(cnt + 1);
  endfunction

endpackage

// File: rtl/adder.sv
// Two-input unsigned adder with carry-in. The result is one bit wider than the
// operands, and its top bit is the carry-out.
module adder #(
  parameter int RES = 8
) (
  input  logic [RES-1:0] a,
  input  logic [RES-1:0] b,
  input  logic           cin,
  output logic [RES:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {{RES{1'b0}}, cin};

endmodule

// File: rtl/stream_accumulator.sv
// Sums CNT unsigned operands into one result and hands it off with a
// valid/ready handshake. Define STREAM_ACC_SAT_EN to clamp overflow.
module stream_accumulator
  import stream_acc_pkg::*;
#(
  parameter int RES  = 4,
  parameter int CNT  = 8,
  parameter int OUTW = RES + $clog2(CNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RES-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUTW-1:0] out_data,
  output logic            out_sat
);

  localparam int CW = cnt_width(CNT);

  state_t          state_q, state_d;
  logic [OUTW-1:0] acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OUTW:0]   sum_w;
  logic [OUTW-1:0] acc_add;
  logic            accept;
  logic            release_result;

  // acc_q is zero whenever the FSM is in IDLE, so the first beat of a result
  // goes through the same adder path as every later beat.
  adder #(.RES(OUTW)) u_adder (
    .a   (acc_q),
    .b   (OUTW'(in_data)),
    .cin (1'b0),
    .sum (sum_w)
  );

  assign in_ready       = (state_q != DONE);
  assign out_valid      = (state_q == DONE);
  assign out_data       = acc_q;
  assign accept         = in_valid && in_ready;
  assign release_result = (state_q == DONE) && out_ready;

`ifdef STREAM_ACC_SAT_EN
  logic sat_q, sat_d;

  // Once the sticky flag is set, the accumulator stays at all ones until the result is released.
  assign acc_add = (sum_w[OUTW] || sat_q) ? '1 : sum_w[OUTW-1:0];
  assign out_sat = sat_q;

  always_comb begin
    sat_d = sat_q;
    if (release_result) begin
      sat_d = 1'b0;
    end else if (accept && sum_w[OUTW]) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  logic unused_carry;

  assign unused_carry = sum_w[OUTW];
  assign acc_add      = sum_w[OUTW-1:0];
  assign out_sat      = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d   = acc_add;
          count_d = count_q + CW'(1);
          state_d = (count_q == CW'(CNT - 1)) ? DONE : ACC;
        end
      end
      DONE: begin
        if (release_result) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every register samples its pre-edge value.
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_stream_accumulator.sv
// Directed bench for stream_accumulator: main config (4/8/7), narrow-output
// overflow config (4/8/4) and single-beat config (4/1/4) share one stimulus.
module tb_stream_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_sat;
  logic [6:0] a_out_data;
  logic       w_in_ready, w_out_valid, w_out_sat;
  logic [3:0] w_out_data;
  logic       c_in_ready, c_out_valid, c_out_sat;
  logic [3:0] c_out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_accumulator #(.RES(4), .CNT(8), .OUTW(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_sat(a_out_sat)
  );

  stream_accumulator #(.RES(4), .CNT(8), .OUTW(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_sat(w_out_sat)
  );

  stream_accumulator #(.RES(4), .CNT(1), .OUTW(4)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .out_sat(c_out_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then examined 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  logic [6:0] exp_w_data;
  logic       exp_w_sat;

  initial begin
`ifdef STREAM_ACC_SAT_EN
    exp_w_data = 7'd15; exp_w_sat = 1'b1;
`else
    exp_w_data = 7'd8;  exp_w_sat = 1'b0;
`endif

    // Reset state.
    do_reset();
    check("rst_in_ready",  a_in_ready,  1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data",  a_out_data,  0);
    check("rst_out_sat",   a_out_sat,   0);

    // Eight back-to-back beats of 15.
    in_valid = 1'b1; in_data = 4'd15;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_ready_%0d", i), a_in_ready, 1);
      check($sformatf("b2b_novalid_%0d", i), a_out_valid, 0);
      step();
    end
    check("b2b_out_valid", a_out_valid, 1);
    check("b2b_out_data",  a_out_data,  120);
    check("b2b_out_sat",   a_out_sat,   0);
    check("ovf_out_data",  w_out_data,  exp_w_data);
    check("ovf_out_sat",   w_out_sat,   exp_w_sat);
    check("ovf_out_valid", w_out_valid, 1);

    // Backpressure: result held, input refused.
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_ready_%0d", i), a_in_ready,  0);
      check($sformatf("hold_valid_%0d", i), a_out_valid, 1);
      check($sformatf("hold_data_%0d", i),  a_out_data,  120);
    end
    out_ready = 1'b1;
    step();
    check("xfer_idle_valid", a_out_valid, 0);
    check("xfer_idle_ready", a_in_ready,  1);
    check("xfer_no_beat",    a_out_data,  0);
    in_valid = 1'b0; out_ready = 1'b0;

    // Beats 1..8 separated by bubbles.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      step();
      in_valid = 1'b0;
      if (i < 8) begin
        step();
        check($sformatf("bubble_novalid_%0d", i), a_out_valid, 0);
      end
    end
    check("bubble_out_valid", a_out_valid, 1);
    check("bubble_out_data",  a_out_data,  36);
    step();
    check("bubble_held",      a_out_data,  36);

    // Reset mid-accumulation discards the partial sum and the reset-cycle beat.
    do_reset();
    in_valid = 1'b1; in_data = 4'd5;
    step(); step(); step();
    rst = 1'b1; in_data = 4'd7;
    step();
    check("midrst_valid", a_out_valid, 0);
    check("midrst_ready", a_in_ready,  1);
    check("midrst_data",  a_out_data,  0);
    rst = 1'b0; in_data = 4'd1;
    for (int i = 0; i < 7; i++) step();
    check("midrst_early", a_out_valid, 0);
    step();
    check("midrst_out_valid", a_out_valid, 1);
    check("midrst_out_data",  a_out_data,  8);

    // Single-beat configuration: IDLE and DONE alternate.
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'd5;
    step();
    check("c1_valid_5", c_out_valid, 1);
    check("c1_data_5",  c_out_data,  5);
    check("c1_ready_5", c_in_ready,  0);
    in_data = 4'd9;
    step();
    check("c1_idle_valid", c_out_valid, 0);
    check("c1_idle_ready", c_in_ready,  1);
    step();
    check("c1_valid_9", c_out_valid, 1);
    check("c1_data_9",  c_out_data,  9);
    in_valid = 1'b0;
    step();
    check("c1_final_idle", c_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_accumulator.md
STREAM_ACCUMULATOR -- requirements
Module: stream_accumulator

Interface
REQ-001 Parameter RES, default 4: operand width in bits.
REQ-002 Parameter CNT, default 8: operands summed per result; CNT >= 1.
REQ-003 Parameter OUTW, default RES+$clog2(CNT): accumulator and result width; OUTW >= RES.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 in_valid  input  1: operand present on in_data.
REQ-007 in_ready  output  1: block accepts an operand this cycle.
REQ-008 in_data  input  RES: unsigned operand.
REQ-009 out_valid  output  1: result present on out_data.
REQ-010 out_ready  input  1: downstream accepts the result this cycle.
REQ-011 out_data  output  OUTW: unsigned accumulated sum.
REQ-012 out_sat  output  1: result was clamped; constant 0 when saturation is compiled out.

Function
REQ-013 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1; out transfer only when out_valid and out_ready are both 1.
REQ-014 States: IDLE (count 0), ACC (1 <= count < CNT), DONE (result held).
REQ-015 IDLE: in_ready=1, out_valid=0; on accepted beat acc <= in_data zero-extended, count <= 1, next = DONE if CNT==1 else ACC.
REQ-016 ACC: in_ready=1, out_valid=0; on accepted beat acc <= acc + in_data, count++; the CNT-th accepted beat moves to DONE.
REQ-017 Cycles with in_valid=0 in IDLE/ACC SHALL leave acc, count and state unchanged.
REQ-018 DONE: in_ready=0, out_valid=1, out_data=acc, out_sat=sticky flag; all outputs held stable until transfer.
REQ-019 DONE with out_ready=1: next = IDLE, acc <= 0, count <= 0, sticky flag <= 0; no input beat is accepted in that same cycle.
REQ-020 Latency: out_valid SHALL rise the cycle after the CNT-th accepted beat; minimum throughput one result per CNT+1 cycles.
REQ-021 Sum SHALL be formed OUTW+1 bits wide; bit OUTW is the overflow carry.
REQ-022 Without saturation, overflow SHALL wrap modulo 2^OUTW.

Reset
REQ-023 rst=1 SHALL force state IDLE, acc=0, count=0, sticky flag=0, out_valid=0, in_ready=1 (in_ready rises the cycle after reset deasserts is not permitted; it is 1 from the first post-reset cycle), out_data=0, out_sat=0.
REQ-024 rst during ACC or DONE SHALL discard partial or pending result; beat presented in the reset cycle is not accepted.

Configuration
REQ-025 Macro STREAM_ACC_SAT_EN defined: on overflow carry acc <= all ones (2^OUTW-1) and sticky flag <= 1; further beats keep acc at all ones.
REQ-026 Macro STREAM_ACC_SAT_EN undefined: wrap per REQ-022; out_sat tied 0; no sticky flag register.

Structure
REQ-027 Package stream_acc_pkg SHALL hold the state enum typedef (IDLE, ACC, DONE) and the count-width helper constant function.
REQ-028 The addition SHALL use one instance of the team's existing two-input adder sub-module (adder, RES=OUTW, a=acc, b=zero-extended in_data, cin=0); no other arithmetic on the datapath.

Verification
REQ-029 RES=4, CNT=8, OUTW=7: 8 back-to-back beats of 15 -> out_valid in cycle 9, out_data=120, out_sat=0.
REQ-030 Beats 1..8 with in_valid bubbles between each -> out_data=36; acc unchanged on bubble cycles.
REQ-031 Result pending, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable at its value, no beat consumed; out_ready=1 -> IDLE next cycle.
REQ-032 rst asserted after 3 beats, then 8 beats of 1 -> out_data=8.
REQ-033 OUTW=4, 8 beats of 15: with STREAM_ACC_SAT_EN -> out_data=15, out_sat=1; without -> out_data=8, out_sat=0.
REQ-034 CNT=1: beats 5, 9 each appear as out_data one cycle after acceptance, alternating IDLE/DONE.
